line_sequencer: RTL

LINE_SEQUENCER -- requirements
Module: line_sequencer

---
 rtl/line_seq_pkg.sv | 24 ++
 rtl/line_seq_frame_timer.sv | 31 +++
 rtl/line_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/line_seq_pkg.sv
// Shared types and constants for the line sequencer: state encoding,
// default parameters and the speed-up divider constants.
package line_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_PLAY,
    ST_HIT,
    ST_OVER
  } state_e;

  localparam int DEF_NUM_LINES     = 4;
  localparam int DEF_STAGGER_FRAMES = 30;
  localparam int DEF_FLASH_HALF    = 15;
  localparam int DEF_FLASH_TOGGLES = 6;

  localparam int CNT_W = 16;

  localparam logic [2:0] SPEED_DIV_START = 3'd4;
  localparam int         SPEED_STEP      = 8;

endpackage

// File: rtl/line_seq_frame_timer.sv
// Frame-interval counter: counts frame pulses and flags the pulse that
// completes an interval of `limit` frames, then wraps to zero.
module line_seq_frame_timer
  import line_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             frame,
  input  logic [CNT_W-1:0] limit,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Must not depend on clear: the FSM derives clear from a next state that uses tick.
  assign tick = frame && ((cnt_q + CNT_W'(1)) >= limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (frame) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/line_sequencer.sv
// Game sequencer: loads gap positions, releases lines on a frame stagger,
// freezes and flashes on a hit, then waits for a fresh start press.
// Optional LINE_SEQ_SPEEDUP_EN adds move_frame, a score-driven frame divider.
module line_sequencer
  import line_seq_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int STAGGER_FRAMES = DEF_STAGGER_FRAMES,
  parameter int FLASH_HALF     = DEF_FLASH_HALF,
  parameter int FLASH_TOGGLES  = DEF_FLASH_TOGGLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame,
  input  logic                 btn_start,
  input  logic [NUM_LINES-1:0] cube_hit,
  input  logic                 cube_pass,
  output logic [NUM_LINES-1:0] start_machine,
  output logic                 load_counter,
  output logic [NUM_LINES-1:0] run,
  output logic                 flash,
  output logic                 game_over,
  output logic [7:0]           score,
`ifdef LINE_SEQ_SPEEDUP_EN
  output logic                 move_frame,
`endif
  output state_e               dbg_state
);

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] sm_q, sm_d, run_q, run_d;
  logic                 flash_q, flash_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           toggles_q, toggles_d;
  logic                 btn_q;
  logic                 tick, hit, score_inc, load_entry;
  logic [NUM_LINES-1:0] sm_shift;

  assign hit       = |cube_hit;
  assign sm_shift  = (sm_q << 1) | NUM_LINES'(1);
  // Hit beats pass on the same cycle.
  assign score_inc = ((state_q == ST_RELEASE) || (state_q == ST_PLAY)) &&
                     cube_pass && !hit && (score_q != 8'hFF);
  assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  line_seq_frame_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .frame   (frame),
    .limit   ((state_q == ST_HIT) ? CNT_W'(FLASH_HALF) : CNT_W'(STAGGER_FRAMES)),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    sm_d      = sm_q;
    run_d     = run_q;
    flash_d   = flash_q;
    toggles_d = toggles_q;
    score_d   = score_inc ? score_q + 8'd1 : score_q;
    case (state_q)
      ST_IDLE: if (btn_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (frame) begin
          state_d = ST_RELEASE;
          sm_d    = NUM_LINES'(1);
          run_d   = NUM_LINES'(1);
        end
      end
      ST_RELEASE, ST_PLAY: begin
        if (hit) begin
          state_d   = ST_HIT;
          run_d     = '0;
          flash_d   = 1'b1;
          toggles_d = '0;
        end else if (state_q == ST_RELEASE) begin
          if (&sm_q) state_d = ST_PLAY;
          else if (tick) begin
            sm_d  = sm_shift;
            run_d = sm_shift;
            if (&sm_shift) state_d = ST_PLAY;
          end
        end
      end
      ST_HIT: begin
        if (tick) begin
          flash_d   = ~flash_q;
          toggles_d = toggles_q + 8'd1;
          if ((toggles_q + 8'd1) >= 8'(FLASH_TOGGLES)) begin
            state_d = ST_OVER;
            flash_d = 1'b1;
          end
        end
      end
      ST_OVER: begin
        flash_d = 1'b1;
        if (btn_start && !btn_q) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_entry) begin
      sm_d      = '0;
      run_d     = '0;
      flash_d   = 1'b0;
      score_d   = '0;
      toggles_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sm_q      <= '0;
      run_q     <= '0;
      flash_q   <= 1'b0;
      score_q   <= '0;
      toggles_q <= '0;
      btn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sm_q      <= sm_d;
      run_q     <= run_d;
      flash_q   <= flash_d;
      score_q   <= score_d;
      toggles_q <= toggles_d;
      btn_q     <= btn_start;
    end
  end

  assign start_machine = sm_q;
  assign run           = run_q;
  assign flash         = flash_q;
  assign score         = score_q;
  assign load_counter  = (state_q == ST_LOAD);
  assign game_over     = (state_q == ST_OVER);
  assign dbg_state     = state_q;

`ifdef LINE_SEQ_SPEEDUP_EN
  logic [2:0] div_q, div_d, step_q, step_d, fdiv_q, fdiv_d;
  logic       fdiv_wrap;

  assign fdiv_wrap  = (fdiv_q + 3'd1) >= div_q;
  assign move_frame = frame && fdiv_wrap;

  always_comb begin
    div_d  = div_q;
    step_d = step_q;
    fdiv_d = fdiv_q;
    if (frame) fdiv_d = fdiv_wrap ? 3'd0 : fdiv_q + 3'd1;
    if (score_inc) begin
      step_d = step_q + 3'd1;
      if ((step_q == 3'(SPEED_STEP - 1)) && (div_q > 3'd1)) div_d = div_q - 3'd1;
    end
    if (load_entry) begin
      div_d  = SPEED_DIV_START;
      step_d = '0;
      fdiv_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= SPEED_DIV_START;
      step_q <= '0;
      fdiv_q <= '0;
    end else begin
      div_q  <= div_d;
      step_q <= step_d;
      fdiv_q <= fdiv_d;
    end
  end
`endif

endmodule
